// File: rtl/muldiv_sequencer_if.sv
// Operand/result bundle between the control unit (master) and the multiply/divide engine (slave).
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) engine, one bit per cycle.
// Optional MULDIV_EARLY_EXIT_EN: DIV with |a| < |b| skips the iteration phase.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StFix, StDone} state_e;

  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // acc doubles as the Booth accumulator and the divide remainder; m as multiplicand / |divisor|.
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;

  always_comb begin
    abs_a = a_q[WIDTH-1] ? (~a_q + One) : a_q;
    abs_b = b_q[WIDTH-1] ? (~b_q + One) : b_q;

    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase

    rem_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    rem_ge    = (rem_shift >= m_q);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    m_d        = m_q;
    q_d        = q_q;
    qm1_d      = qm1_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d       = bus.op;
          a_d        = bus.a;
          b_d        = bus.b;
          div_zero_d = 1'b0;
          state_d    = StLoad;
        end
      end

      StLoad: begin
        acc_d = '0;
        qm1_d = 1'b0;
        if (!op_q) begin
          q_d     = b_q;
          m_d     = {a_q[WIDTH-1], a_q};
          cnt_d   = CntInit;
          state_d = StRun;
        end else begin
          q_d        = abs_a;
          m_d        = {1'b0, abs_b};
          neg_quot_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_rem_d  = a_q[WIDTH-1];
          if (b_q == '0) begin
            div_zero_d = 1'b1;
            state_d    = StDone;
          end
`ifdef MULDIV_EARLY_EXIT_EN
          else if (abs_a < abs_b) begin
            acc_d   = {1'b0, abs_a};
            q_d     = '0;
            state_d = StFix;
          end
`endif
          else begin
            cnt_d   = CntInit;
            state_d = StRun;
          end
        end
      end

      StRun: begin
        cnt_d = cnt_q - CntOne;
        if (!op_q) begin
          // Arithmetic right shift of {acc, Q, q_-1} after the Booth add/subtract.
          acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
        end else if (rem_ge) begin
          acc_d = rem_shift - m_q;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift;
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CntOne) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (!op_q) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = q_q;
        end else begin
          hi_d = neg_rem_q ? (~acc_q[WIDTH-1:0] + One) : acc_q[WIDTH-1:0];
          lo_d = neg_quot_q ? (~q_q + One) : q_q;
        end
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      m_q        <= m_d;
      q_q        <= q_d;
      qm1_q      <= qm1_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at start, checked at done.
module tb_muldiv_sequencer;

`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   t0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;
  exp_t sb[$];

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("hi", 64'(bus.hi), 64'(e.hi));
        check_eq("lo", 64'(bus.lo), 64'(e.lo));
        check_eq("div_zero", 64'(bus.div_zero), 64'(e.dz));
        check_eq("done_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("busy_at_done", 64'(bus.busy), 64'd1);
      end
    end
  end

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input logic dz,
                          input int lat);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.dz  = dz;
    e.cyc = t0 + lat;
    sb.push_back(e);
    if (!dz) begin
      last_hi = h;
      last_lo = l;
    end
  endtask

  // Starts an op in cycle t0, checks busy around the start, returns inside cycle t0+1.
  task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input logic dz,
                          input int lat);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    t0        = cyc;
    push_exp(h, l, dz, lat);
    @(negedge clk);
    check_eq("busy_c0", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(negedge clk);
    check_eq("busy_c1", 64'(bus.busy), 64'd1);
    check_eq("dz_clear_c1", 64'(bus.div_zero), 64'd0);
  endtask

  task automatic pulse_at(input int target, input logic op, input logic [31:0] a,
                          input logic [31:0] b);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    check_eq("busy_after", 64'(bus.busy), 64'd0);
  endtask

  task automatic run_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_v, p, qv, rv;
    int lat;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    if (!op) begin
      p = sa * sb_v;
      start_op(op, a, b, p[63:32], p[31:0], 1'b0, 35);
    end else if (b == 32'd0) begin
      start_op(op, a, b, last_hi, last_lo, 1'b1, 2);
    end else begin
      qv  = sa / sb_v;
      rv  = sa % sb_v;
      lat = (Early && ((sa < 0 ? -sa : sa) < (sb_v < 0 ? -sb_v : sb_v))) ? 3 : 35;
      start_op(op, a, b, rv[31:0], qv[31:0], 1'b0, lat);
    end
    wait_idle();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    t0        = 0;
    last_hi   = '0;
    last_lo   = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    check_eq("rst_dz", 64'(bus.div_zero), 64'd0);

    start_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35);
    wait_idle();
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35);
    wait_idle();

    // 0x451 / 0x20 leaves hi = 0x11, lo = 0x22 for the divide-by-zero check.
    start_op(1'b1, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 35);
    wait_idle();
    start_op(1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 2);
    wait_idle();
    check_eq("dz_held", 64'(bus.div_zero), 64'd1);

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 35);
    wait_idle();
    start_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 35);
    wait_idle();
    start_op(1'b1, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFE, 32'h0, 1'b0, Early ? 3 : 35);
    wait_idle();

    // Starts while busy and in the DONE cycle must not disturb the running op.
    start_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 35);
    pulse_at(t0 + 10, 1'b0, 32'd5, 32'd6);
    pulse_at(t0 + 35, 1'b0, 32'd5, 32'd6);
    wait_idle();
    repeat (40) @(negedge clk);
    check_eq("ignored_start_idle", 64'(bus.busy), 64'd0);

    // Reset mid-operation: no done, outputs back to reset values.
    pulse_at(cyc + 1, 1'b0, 32'd3, 32'd4);
    t0 = cyc - 1;
    pulse_at(t0 + 10, 1'b0, 32'd9, 32'd9);
    while (cyc < t0 + 20) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_rst_hi", 64'(bus.hi), 64'd0);
    check_eq("mid_rst_lo", 64'(bus.lo), 64'd0);
    check_eq("mid_rst_dz", 64'(bus.div_zero), 64'd0);
    repeat (40) @(negedge clk);
    start_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 35);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      logic        rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom >> $urandom_range(0, 31);
      rb  = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if (i == 5) rop = 1'b1;
      run_model(rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
